mdio_master: RTL and testbench
==============================

# mdio_master

Clause-22 MDIO management initiator: accepts single read/write commands on a valid/ready interface, generates MDC, serialises preamble/ST/OP/PHYAD/REGAD/TA/data onto MDIO and returns read data. Sits between the Ethernet control logic and the PHY management pins. The pad tristate (`eth_mdio`) is built at top level from `mdio_o`/`mdio_oe`/`mdio_i`.

## Interface
- `CLK_DIV`, 20: MDC half-period in `clk` cycles (legal 1..255); 100 MHz `clk` gives 2.5 MHz MDC.

One clock; reset is asynchronous and active-low.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: idle, able to accept.
- `cmd_write` in 1: 1 = write (OP 01), 0 = read (OP 10).
- `cmd_phy_addr` in 5: PHYAD.
- `cmd_reg_addr` in 5: REGAD.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle pulse, frame complete (reads and writes).
- `rsp_rdata` out 16: read data, valid with `rsp_valid`; 0 for writes.
- `rsp_err` out 1: read TA bit 2 sampled 1 (no PHY response); valid with `rsp_valid`.
- `mdc` out 1: management clock.
- `mdio_o` out 1: MDIO drive value.
- `mdio_oe` out 1: MDIO drive enable.
- `mdio_i` in 1: MDIO sampled pad value.

## Operation
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0. The state is IDLE and the bit counter is 0.
- `cmd_ready` goes high on the first `clk` after reset deasserts. It is high only in IDLE.
- A command is accepted on `cmd_valid && cmd_ready`. All command fields are latched at acceptance, and `cmd_ready` drops on the next cycle.
- States and transitions:
  - IDLE -> PREAMBLE, after 32 bits -> START.
  - START, 2 bits -> OPCODE.
  - OPCODE, 2 bits -> PHY_ADDR.
  - PHY_ADDR, 5 bits -> REG_ADDR.
  - REG_ADDR, 5 bits -> TA.
  - TA, 2 bits -> DATA.
  - DATA, 16 bits -> DONE.
  - DONE, 1 idle bit -> IDLE.
- All fields are sent MSB first. The frame is ones×32, `01`, OP, PHYAD, REGAD, TA, data.
- Write: the master drives TA `10` and then `cmd_wdata`. `mdio_oe`=1 from PREAMBLE through DATA.
- Read: `mdio_oe`=0 for both TA bits and all DATA bits.
  - TA bit 2 sampled: if it is 1, `rsp_err` is set. The frame still runs to completion.
  - Each data bit is shifted into `rsp_rdata`. An absent PHY yields 16'hFFFF.
- DONE: `mdio_oe`=0, `mdio_o`=1, `mdc` held low for one bit period. Then IDLE.
- Simultaneous `cmd_valid` during a frame: ignored, because `cmd_ready`=0. No queueing.
- Reset asserted mid-frame: all outputs go to their reset values immediately. No `rsp_valid` is issued for the aborted frame.

## Timing
- Let D = `CLK_DIV`. Acceptance is at cycle 0.
- Bit i (0-based over the frame) occupies cycles 1+2Di .. 2D(i+1).
  - `mdc` is low for the first D cycles and high for the last D.
  - `mdio_o`/`mdio_oe` change only in the first cycle of a bit period, i.e. on the MDC falling edge.
- Read sampling: `mdio_i` is sampled in the `clk` cycle where `mdc` transitions 0->1 within the bit period.
- Frame length N = 64 bits.
- `rsp_valid` pulses at cycle 2DN+1, i.e. 128D+1 with the preamble.
- `cmd_ready` reasserts at cycle 2D(N+1)+1, so the back-to-back command period is 2D(N+1)+1 cycles.
- `mdc` is low whenever the state is IDLE or DONE.

## Configuration
- `MDIO_PREAMBLE_EN` defined: the 32-bit preamble of ones is sent. N=64.
- Not defined: preamble suppression. The frame starts at ST, PREAMBLE is never entered, N=32, and `rsp_valid` arrives at cycle 64D+1.
- Suppression is only valid with PHYs that accept preamble suppression.

## Structure
- Package `mdio_pkg`:
  - State enum `mdio_state_t`.
  - `MDIO_ST`=2'b01, `MDIO_OP_WRITE`=2'b01, `MDIO_OP_READ`=2'b10.
  - `MDIO_PREAMBLE_BITS`=32, `MDIO_DATA_BITS`=16.
- Sub-module `mdio_clkgen`, parameter `CLK_DIV`:
  - `$clog2`-width divider, enabled only while a frame is active.
  - Outputs `mdc` and one-cycle `mdc_rise`/`mdc_fall` strobes that drive the shift FSM.

## Test plan
All scenarios use D=2, `MDIO_PREAMBLE_EN` defined, and the team's PHY responder model.

- Read reg 1 from PHY addr 0 (model returns 16'h7849):
  - `mdio_o` sequence ones×32, 01, 10, 00000, 00001 while `mdio_oe`=1.
  - `rsp_valid` at cycle 257 with `rsp_rdata`=16'h7849 and `rsp_err`=0.
- Write PHY 1, reg 0, data 16'h1200:
  - Captured bits are 32 ones, 01, 01, 00001, 00000, 10, then 0x1200 MSB first.
  - `mdio_oe` stays 1 through the last data bit.
  - `rsp_valid` with `rsp_rdata`=0.
- Read with the PHY model disconnected (`mdio_i` pulled to 1) -> `rsp_err`=1, `rsp_rdata`=16'hFFFF.
- `cmd_valid` held high across two commands:
  - Second acceptance exactly 2D·65+1 = 261 cycles after the first.
  - `cmd_ready`=0 throughout the first frame.
- Reset pulsed at cycle 100 of a read:
  - `mdc`=0, `mdio_oe`=0, `mdio_o`=1 immediately, with no `rsp_valid`.
  - `cmd_ready`=1 one cycle after release.
- `MDIO_PREAMBLE_EN` undefined:
  - The first driven bits are 0 then 1 (ST).
  - Read of reg 1 completes with `rsp_valid` at cycle 129 and `rsp_rdata`=16'h7849.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO initiator.
// Field lengths and ordering of the management frame live here.
package mdio_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        START,
        OPCODE,
        PHY_ADDR,
        REG_ADDR,
        TA,
        DATA,
        DONE
    } mdio_state_t;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

    localparam int MDIO_PREAMBLE_BITS = 32;
    localparam int MDIO_DATA_BITS     = 16;

    // Index of the last bit of each field; DONE is one idle bit period.
    function automatic logic [4:0] field_last(input mdio_state_t s);
        case (s)
            PREAMBLE:          return 5'(MDIO_PREAMBLE_BITS - 1);
            START, OPCODE, TA: return 5'd1;
            PHY_ADDR, REG_ADDR: return 5'd4;
            DATA:              return 5'(MDIO_DATA_BITS - 1);
            default:           return 5'd0;
        endcase
    endfunction

    function automatic mdio_state_t field_next(input mdio_state_t s);
        case (s)
            PREAMBLE: return START;
            START:    return OPCODE;
            OPCODE:   return PHY_ADDR;
            PHY_ADDR: return REG_ADDR;
            REG_ADDR: return TA;
            TA:       return DATA;
            DATA:     return DONE;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: runs only while a frame is active, one MDC period is 2*CLK_DIV clk cycles.
// Emits single-cycle strobes one clk before each MDC rising/falling edge.
module mdio_clkgen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold_low,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             mdc_reg;

    assign mdc_rise = en && (cnt_reg == RISE_AT);
    assign mdc_fall = en && (cnt_reg == FALL_AT);
    assign mdc      = mdc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            mdc_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg <= '0;
            mdc_reg <= 1'b0;
        end else if (mdc_fall) begin
            cnt_reg <= '0;
            mdc_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            // The idle bit after the data phase keeps MDC low for a full period.
            if (mdc_rise) mdc_reg <= !hold_low;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: one command per frame, read data returned on rsp_*.
// Define MDIO_PREAMBLE_EN to send the 32-bit preamble; otherwise frames start at ST.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    mdio_state_t state_reg, state_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [31:0] tx_reg, tx_next;
    logic        write_reg, write_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic        mdio_o_reg, mdio_o_next;
    logic        mdio_oe_reg, mdio_oe_next;
    logic [31:0] cmd_frame;
    logic        mdc_rise, mdc_fall;

    // Reads carry ones in TA/data so the released line shows the idle level.
    assign cmd_frame = {MDIO_ST,
                        cmd_write ? MDIO_OP_WRITE : MDIO_OP_READ,
                        cmd_phy_addr, cmd_reg_addr,
                        cmd_write ? MDIO_TA_WRITE : 2'b11,
                        cmd_write ? cmd_wdata : 16'hFFFF};

    mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg != IDLE),
        .hold_low (state_reg == DONE),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            tx_reg        <= '0;
            write_reg     <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            mdio_o_reg    <= 1'b1;
            mdio_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            tx_reg        <= tx_next;
            write_reg     <= write_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            mdio_o_reg    <= mdio_o_next;
            mdio_oe_reg   <= mdio_oe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        tx_next        = tx_reg;
        write_next     = write_reg;
        cmd_ready_next = cmd_ready_reg;
        rsp_valid_next = 1'b0;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        mdio_o_next    = mdio_o_reg;
        mdio_oe_next   = mdio_oe_reg;

        case (state_reg)
            IDLE: begin
                cmd_ready_next = 1'b1;
                mdio_o_next    = 1'b1;
                mdio_oe_next   = 1'b0;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    write_next     = cmd_write;
                    rdata_next     = '0;
                    err_next       = 1'b0;
                    bit_cnt_next   = '0;
                    mdio_oe_next   = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_next     = PREAMBLE;
                    tx_next        = cmd_frame;
                    mdio_o_next    = 1'b1;
`else
                    state_next     = START;
                    tx_next        = {cmd_frame[30:0], 1'b0};
                    mdio_o_next    = cmd_frame[31];
`endif
                end
            end
            default: begin
                // Sample on the clk edge that raises MDC.
                if (mdc_rise && !write_reg) begin
                    if (state_reg == TA && bit_cnt_reg == 5'd1) err_next = mdio_i;
                    if (state_reg == DATA) rdata_next = {rdata_reg[14:0], mdio_i};
                end
                if (mdc_fall) begin
                    if (bit_cnt_reg == field_last(state_reg)) begin
                        state_next   = field_next(state_reg);
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                    case (state_next)
                        DONE: begin
                            mdio_o_next    = 1'b1;
                            mdio_oe_next   = 1'b0;
                            rsp_valid_next = 1'b1;
                        end
                        IDLE: begin
                            mdio_o_next    = 1'b1;
                            mdio_oe_next   = 1'b0;
                            cmd_ready_next = 1'b1;
                        end
                        PREAMBLE: begin
                            mdio_o_next  = 1'b1;
                            mdio_oe_next = 1'b1;
                        end
                        default: begin
                            mdio_o_next  = tx_reg[31];
                            tx_next      = {tx_reg[30:0], 1'b0};
                            mdio_oe_next = write_reg || !(state_next == TA || state_next == DATA);
                        end
                    endcase
                end
            end
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;
    assign mdio_o    = mdio_o_reg;
    assign mdio_oe   = mdio_oe_reg;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: frame-level model of the expected pin waveform plus a PHY responder.
// Adapts to MDIO_PREAMBLE_EN (64-bit frames) or its absence (32-bit frames).
module tb_mdio_master;

    localparam int D = 2;
`ifdef MDIO_PREAMBLE_EN
    localparam int P       = 32;
    localparam int EXP_RSP = 257;
    localparam int EXP_B2B = 261;
`else
    localparam int P       = 0;
    localparam int EXP_RSP = 129;
    localparam int EXP_B2B = 133;
`endif
    localparam int N = P + 32;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err;
    logic        mdc, mdio_o, mdio_oe, mdio_i;

    mdio_master #(.CLK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Frame model state
    bit          m_active = 1'b0;
    bit          m_ready  = 1'b0;
    int          m_rel    = 0;
    bit          m_write  = 1'b0;
    logic [15:0] m_phy_data  = '0;
    logic [15:0] m_exp_rdata = '0;
    bit          m_exp_err   = 1'b0;
    bit          m_bits [64];
    bit          m_oe   [64];
    bit          phy_connected = 1'b1;
    int          acc_count = 0;
    int          acc_cyc [16];
    logic [63:0] cap = '0;
    int          rsp_seen = 0;
    int          last_rsp_rel = 0;
    logic [15:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] phy_value(input logic [4:0] pa, input logic [4:0] ra);
        if (pa == 5'd0 && ra == 5'd1) return 16'h7849;
        if (pa == 5'd3 && ra == 5'd2) return 16'hA5C3;
        return 16'h1234 ^ {6'b0, pa, ra};
    endfunction

    // Model: advances at each clk edge using the inputs the DUT saw at that edge.
    initial begin
        logic [63:0] fr;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_active = 1'b0;
                m_ready  = 1'b0;
            end else if (m_active) begin
                m_rel++;
                if (m_rel == 2 * D * (N + 1) + 1) begin
                    m_active = 1'b0;
                    m_ready  = 1'b1;
                end
            end else if (m_ready && cmd_valid) begin
                fr = {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                      cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'h0000};
                for (int i = 0; i < N; i++) begin
                    m_bits[i] = fr[N-1-i];
                    m_oe[i]   = cmd_write || (i < P + 14);
                end
                m_write     = cmd_write;
                m_phy_data  = phy_value(cmd_phy_addr, cmd_reg_addr);
                m_exp_rdata = cmd_write ? 16'h0000 : (phy_connected ? m_phy_data : 16'hFFFF);
                m_exp_err   = !cmd_write && !phy_connected;
                if (acc_count < 16) acc_cyc[acc_count] = cyc - 1;
                acc_count++;
                cap      = '0;
                m_active = 1'b1;
                m_rel    = 1;
                m_ready  = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Compare process and PHY responder, on the falling clk edge.
    initial begin
        logic [4:0] e, a;
        bit         o_dc;
        int         c, i, ph;
        mdio_i = 1'b1;
        forever begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            o_dc = 1'b0;
            if (!rst) begin
                e = 5'b01000;
                mdio_i = 1'b1;
                check("reset_rsp", {rsp_err, rsp_rdata}, 17'h0);
            end else if (m_active) begin
                c = m_rel;
                if (c <= 2 * D * N) begin
                    i  = (c - 1) / (2 * D);
                    ph = (c - 1) % (2 * D);
                    e  = {(ph >= D) ? 1'b1 : 1'b0, m_bits[i], m_oe[i], 1'b0, 1'b0};
                    o_dc = !m_oe[i];
                    if (ph == D) cap = {cap[62:0], mdio_o};
                    if (!m_write && phy_connected && i >= P + 15)
                        mdio_i = (i == P + 15) ? 1'b0 : m_phy_data[31 + P - i];
                    else
                        mdio_i = 1'b1;
                end else begin
                    e = {1'b0, 1'b1, 1'b0, 1'b0, (c == 2 * D * N + 1) ? 1'b1 : 1'b0};
                    mdio_i = 1'b1;
                    if (c == 2 * D * N + 1) begin
                        check("rsp_payload", {rsp_err, rsp_rdata}, {m_exp_err, m_exp_rdata});
                        $display("rsp cyc=%0d write=%0b rdata=%04h err=%0b", cyc, m_write, rsp_rdata, rsp_err);
                    end
                end
                if (rsp_valid) begin
                    last_rsp_rel = c;
                    last_rdata   = rsp_rdata;
                    last_err     = rsp_err;
                end
            end else begin
                e = {1'b0, 1'b1, 1'b0, m_ready, 1'b0};
                mdio_i = 1'b1;
            end
            a = {mdc, mdio_o, mdio_oe, cmd_ready, rsp_valid};
            if (o_dc) a[3] = e[3];
            check("pins_mdc_o_oe_rdy_vld", a, e);
        end
    end

    task automatic send(input logic w, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        int start;
        start        = acc_count;
        cmd_write    = w;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (acc_count != start) break;
        end
        cmd_valid = 1'b0;
        check("accept_timeout", acc_count - start, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (!m_active && m_ready) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", done, 1);
    endtask

    initial begin
        int start, rsp_before;
        bit hit;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_phy_addr = '0;
        cmd_reg_addr = '0;
        cmd_wdata = '0;

        repeat (5) @(posedge clk);
        #1;
        check("reset_ready", cmd_ready, 0);
        check("reset_mdio_o", mdio_o, 1);
        check("reset_mdc", mdc, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", cmd_ready, 1);

        // Read PHY 0 reg 1
        send(1'b0, 5'd0, 5'd1, 16'h0);
        wait_idle();
        check("rd_rsp_cycle", last_rsp_rel, EXP_RSP);
        check("rd_rdata", last_rdata, 16'h7849);
        check("rd_err", last_err, 0);
        check("rd_header_bits", cap[31:18], 14'h1801);
`ifdef MDIO_PREAMBLE_EN
        check("rd_preamble", cap[63:32], 32'hFFFF_FFFF);
`endif

        // Write PHY 1 reg 0
        send(1'b1, 5'd1, 5'd0, 16'h1200);
        wait_idle();
        check("wr_bits", cap[31:0], 32'h5082_1200);
        check("wr_rdata", last_rdata, 16'h0000);
        check("wr_rsp_cycle", last_rsp_rel, EXP_RSP);

        // Write with all-ones address fields and data
        send(1'b1, 5'd31, 5'd31, 16'hFFFF);
        wait_idle();
        check("wr_ones_bits", cap[31:0], 32'h5FFE_FFFF);

        // Read with no PHY answering
        phy_connected = 1'b0;
        send(1'b0, 5'd5, 5'd3, 16'h0);
        wait_idle();
        check("nophy_err", last_err, 1);
        check("nophy_rdata", last_rdata, 16'hFFFF);
        phy_connected = 1'b1;

        // Another read pattern
        send(1'b0, 5'd3, 5'd2, 16'h0);
        wait_idle();
        check("rd2_rdata", last_rdata, 16'hA5C3);
        check("rd2_err", last_err, 0);

        // cmd_valid held across two commands
        start        = acc_count;
        cmd_write    = 1'b0;
        cmd_phy_addr = 5'd0;
        cmd_reg_addr = 5'd1;
        cmd_valid    = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(posedge clk);
            #1;
            if (acc_count >= start + 2) break;
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", acc_count - start, 2);
        if (start + 1 < 16)
            check("b2b_period", acc_cyc[start+1] - acc_cyc[start], EXP_B2B);
        wait_idle();

        // Reset pulsed in the middle of a read
        send(1'b0, 5'd0, 5'd1, 16'h0);
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (m_active && m_rel == 100) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_cycle_100", hit, 1);
        rsp_before = rsp_seen;
        rst = 1'b0;
        #1;
        check("abort_mdc", mdc, 0);
        check("abort_oe", mdio_oe, 0);
        check("abort_mdio_o", mdio_o, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after_release", cmd_ready, 1);
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_seen, rsp_before);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout, required completion at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
